// File: rtl/spram_arb_pkg.sv
// Shared constants and helpers for the two-requester single-port SRAM arbiter.
// Owner encoding is used by the response-steering register in the top level.
package spram_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 14;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BE_WIDTH           = DEFAULT_DATA_WIDTH / 8;
  localparam int DEFAULT_MAX_WAIT   = 4;

  // wait_cnt is sized for the largest legal MAX_WAIT (15).
  localparam int WAIT_W = 4;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE = 2'd0;
  localparam owner_t OWNER_M0   = 2'd1;
  localparam owner_t OWNER_M1   = 2'd2;

  function automatic owner_t owner_of(input logic [1:0] gnt);
    owner_t o;
    o = OWNER_NONE;
    if (gnt[0]) o = OWNER_M0;
    else if (gnt[1]) o = OWNER_M1;
    return o;
  endfunction

endpackage

// File: rtl/spram_arb_pick.sv
// Combinational winner selection: fixed priority with m1 anti-starvation, or
// round-robin. gnt_o is one-hot or zero; force_o marks a starvation-forced m1 win.
module spram_arb_pick
  import spram_arb_pkg::*;
#(
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              m0_valid_i,
  input  logic              m1_valid_i,
  input  logic              last_gnt_i,
  input  logic [WAIT_W-1:0] wait_cnt_i,
  output logic [1:0]        gnt_o,
  output logic              force_o
);

  always_comb begin
    gnt_o   = 2'b00;
    force_o = 1'b0;
    case ({m1_valid_i, m0_valid_i})
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (RR_MODE != 0) begin
          // last_gnt_i = 1 means m1 won last time, so m0 goes next.
          gnt_o = last_gnt_i ? 2'b01 : 2'b10;
        end else if (wait_cnt_i == WAIT_W'(MAX_WAIT)) begin
          gnt_o   = 2'b10;
          force_o = 1'b1;
        end else begin
          gnt_o = 2'b01;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port SRAM: one access per cycle,
// SRAM pins driven combinationally from the grant, response returned one cycle later.
//
// Handshake: a request transfers on the rising edge where valid & ready are both 1;
// the requester holds valid/wstrb/addr/wdata stable until then. ready depends only on
// the valid inputs and registered arbiter state, and at most one ready is high.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RR_MODE    = 0,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,

  input  logic                    m0_valid_i,
  output logic                    m0_ready_o,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_valid_i,
  output logic                    m1_ready_o,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic [DATA_WIDTH/8-1:0] ram_wenb_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic                    starve_o
);

  localparam int BW = DATA_WIDTH / 8;

  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  owner_t                rsp_owner_q, rsp_owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0]            pick_gnt;
  logic                  pick_force;
  logic [1:0]            gnt;
  logic                  any_gnt;
  logic [BW-1:0]         win_wstrb;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  spram_arb_pick #(
    .RR_MODE  (RR_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .m0_valid_i (m0_valid_i),
    .m1_valid_i (m1_valid_i),
    .last_gnt_i (last_gnt_q),
    .wait_cnt_i (wait_cnt_q),
    .gnt_o      (pick_gnt),
    .force_o    (pick_force)
  );

  // Grants are suppressed while reset is held so the SRAM never sees a write.
  always_comb begin
    gnt      = rst_n_i ? pick_gnt : 2'b00;
    any_gnt  = |gnt;
    starve_o = rst_n_i & pick_force;
  end

  always_comb begin
    win_wstrb = m0_wstrb_i;
    win_addr  = m0_addr_i;
    win_wdata = m0_wdata_i;
    if (gnt[1]) begin
      win_wstrb = m1_wstrb_i;
      win_addr  = m1_addr_i;
      win_wdata = m1_wdata_i;
    end
  end

  always_comb begin
    m0_ready_o  = gnt[0];
    m1_ready_o  = gnt[1];
    ram_wenb_o  = any_gnt ? ~win_wstrb : {BW{1'b1}};
    ram_addr_o  = any_gnt ? win_addr : addr_q;
    ram_wdata_o = any_gnt ? win_wdata : wdata_q;
  end

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    last_gnt_d  = last_gnt_q;
    rsp_owner_d = owner_of(gnt);
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (!m1_valid_i || gnt[1]) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    if (any_gnt) begin
      last_gnt_d = gnt[1];
      addr_d     = win_addr;
      wdata_d    = win_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_q  <= '0;
      last_gnt_q  <= 1'b1;
      rsp_owner_q <= OWNER_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      last_gnt_q  <= last_gnt_d;
      rsp_owner_q <= rsp_owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // SRAM data arrives the cycle after the address, so it is steered by rsp_owner_q.
  always_comb begin
    m0_rvalid_o = (rsp_owner_q == OWNER_M0);
    m1_rvalid_o = (rsp_owner_q == OWNER_M1);
    m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
  end

  a_m0_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (m0_valid_i && !m0_ready_o) |=>
      (m0_valid_i && $stable(m0_addr_i) && $stable(m0_wstrb_i) && $stable(m0_wdata_i)));

  a_m1_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (m1_valid_i && !m1_ready_o) |=>
      (m1_valid_i && $stable(m1_addr_i) && $stable(m1_wstrb_i) && $stable(m1_wdata_i)));

  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(m0_ready_o && m1_ready_o));

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: instance "a" uses fixed priority (RR_MODE=0,
// MAX_WAIT=4), instance "b" uses round-robin; each has its own behavioural SRAM.
module tb_spram_arbiter;

  logic clk;
  logic rst_n;

  logic        a_m0_valid, a_m0_ready, a_m0_rvalid;
  logic [3:0]  a_m0_wstrb;
  logic [13:0] a_m0_addr;
  logic [31:0] a_m0_wdata, a_m0_rdata;
  logic        a_m1_valid, a_m1_ready, a_m1_rvalid;
  logic [3:0]  a_m1_wstrb;
  logic [13:0] a_m1_addr;
  logic [31:0] a_m1_wdata, a_m1_rdata;
  logic [3:0]  a_wenb;
  logic [13:0] a_addr;
  logic [31:0] a_wdata, a_ram_rdata;
  logic        a_starve;

  logic        b_m0_valid, b_m0_ready, b_m0_rvalid;
  logic [3:0]  b_m0_wstrb;
  logic [13:0] b_m0_addr;
  logic [31:0] b_m0_wdata, b_m0_rdata;
  logic        b_m1_valid, b_m1_ready, b_m1_rvalid;
  logic [3:0]  b_m1_wstrb;
  logic [13:0] b_m1_addr;
  logic [31:0] b_m1_wdata, b_m1_rdata;
  logic [3:0]  b_wenb;
  logic [13:0] b_addr;
  logic [31:0] b_wdata, b_ram_rdata;
  logic        b_starve;

  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];

  int checks   = 0;
  int failures = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .RR_MODE(0), .MAX_WAIT(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_valid_i(a_m0_valid), .m0_ready_o(a_m0_ready), .m0_wstrb_i(a_m0_wstrb),
    .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata), .m0_rvalid_o(a_m0_rvalid),
    .m0_rdata_o(a_m0_rdata),
    .m1_valid_i(a_m1_valid), .m1_ready_o(a_m1_ready), .m1_wstrb_i(a_m1_wstrb),
    .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata), .m1_rvalid_o(a_m1_rvalid),
    .m1_rdata_o(a_m1_rdata),
    .ram_wenb_o(a_wenb), .ram_addr_o(a_addr), .ram_wdata_o(a_wdata),
    .ram_rdata_i(a_ram_rdata), .starve_o(a_starve)
  );

  spram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .RR_MODE(1), .MAX_WAIT(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_valid_i(b_m0_valid), .m0_ready_o(b_m0_ready), .m0_wstrb_i(b_m0_wstrb),
    .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata), .m0_rvalid_o(b_m0_rvalid),
    .m0_rdata_o(b_m0_rdata),
    .m1_valid_i(b_m1_valid), .m1_ready_o(b_m1_ready), .m1_wstrb_i(b_m1_wstrb),
    .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata), .m1_rvalid_o(b_m1_rvalid),
    .m1_rdata_o(b_m1_rdata),
    .ram_wenb_o(b_wenb), .ram_addr_o(b_addr), .ram_wdata_o(b_wdata),
    .ram_rdata_i(b_ram_rdata), .starve_o(b_starve)
  );

  // Behavioural SRAMs: byte writes on active-low enables, registered read data.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!a_wenb[k]) mem_a[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
    a_ram_rdata <= mem_a[a_addr];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!b_wenb[k]) mem_b[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
    b_ram_rdata <= mem_b[b_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a0(input logic v, input logic [3:0] s, input logic [13:0] ad,
                          input logic [31:0] d);
    a_m0_valid = v; a_m0_wstrb = s; a_m0_addr = ad; a_m0_wdata = d;
  endtask

  task automatic drive_a1(input logic v, input logic [3:0] s, input logic [13:0] ad,
                          input logic [31:0] d);
    a_m1_valid = v; a_m1_wstrb = s; a_m1_addr = ad; a_m1_wdata = d;
  endtask

  initial begin
    logic exp_m1;
    logic prev_m1;

    rst_n = 1'b0;
    drive_a0(1'b1, 4'h0, 14'h0005, 32'h0);
    drive_a1(1'b1, 4'h0, 14'h0006, 32'h0);
    b_m0_valid = 1'b0; b_m0_wstrb = 4'h0; b_m0_addr = 14'h0; b_m0_wdata = 32'h0;
    b_m1_valid = 1'b0; b_m1_wstrb = 4'h0; b_m1_addr = 14'h0; b_m1_wdata = 32'h0;

    // Reset with both requesters valid
    @(negedge clk); #1;
    check("rst_wenb", {28'h0, a_wenb}, 32'hF);
    check("rst_ready", {30'h0, a_m1_ready, a_m0_ready}, 32'h0);
    check("rst_rvalid", {30'h0, a_m1_rvalid, a_m0_rvalid}, 32'h0);
    check("rst_starve", {31'h0, a_starve}, 32'h0);
    check("rst_addr", {18'h0, a_addr}, 32'h0);
    check("rst_rdata", a_m0_rdata | a_m1_rdata, 32'h0);

    // Release; both stay valid: m0 x4 then forced m1, twice
    @(negedge clk);
    rst_n = 1'b1;
    prev_m1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_m1 = ((i % 5) == 4);
      check($sformatf("fp_m0_ready[%0d]", i), {31'h0, a_m0_ready}, {31'h0, !exp_m1});
      check($sformatf("fp_m1_ready[%0d]", i), {31'h0, a_m1_ready}, {31'h0, exp_m1});
      check($sformatf("fp_starve[%0d]", i), {31'h0, a_starve}, {31'h0, exp_m1});
      check($sformatf("fp_addr[%0d]", i), {18'h0, a_addr}, exp_m1 ? 32'h6 : 32'h5);
      if (i > 0) begin
        check($sformatf("fp_m0_rvalid[%0d]", i), {31'h0, a_m0_rvalid}, {31'h0, !prev_m1});
        check($sformatf("fp_m1_rvalid[%0d]", i), {31'h0, a_m1_rvalid}, {31'h0, prev_m1});
      end else begin
        check("fp_rvalid_first", {30'h0, a_m1_rvalid, a_m0_rvalid}, 32'h0);
      end
      prev_m1 = exp_m1;
      @(negedge clk);
    end
    a_m1_valid = 1'b0;
    #1;
    check("fp_tail_m0_ready", {31'h0, a_m0_ready}, 32'h1);
    check("fp_tail_m1_rvalid", {31'h0, a_m1_rvalid}, 32'h1);
    @(negedge clk);
    a_m0_valid = 1'b0;
    #1;
    check("fp_tail_m0_rvalid", {31'h0, a_m0_rvalid}, 32'h1);
    check("idle_wenb", {28'h0, a_wenb}, 32'hF);
    check("idle_addr_held", {18'h0, a_addr}, 32'h5);

    // m0 full-word write then read of 0x0010
    @(negedge clk);
    drive_a0(1'b1, 4'hF, 14'h0010, 32'hDEADBEEF);
    #1;
    check("wr_ready", {31'h0, a_m0_ready}, 32'h1);
    check("wr_wenb", {28'h0, a_wenb}, 32'h0);
    check("wr_addr", {18'h0, a_addr}, 32'h10);
    check("wr_wdata", a_wdata, 32'hDEADBEEF);
    @(negedge clk);
    drive_a0(1'b1, 4'h0, 14'h0010, 32'h0);
    #1;
    check("wr_ack", {31'h0, a_m0_rvalid}, 32'h1);
    check("rd_wenb", {28'h0, a_wenb}, 32'hF);
    @(negedge clk);
    a_m0_valid = 1'b0;
    #1;
    check("rd_rvalid", {31'h0, a_m0_rvalid}, 32'h1);
    check("rd_rdata", a_m0_rdata, 32'hDEADBEEF);
    check("rd_m1_gated", a_m1_rdata, 32'h0);

    // m1 byte-lane-2 write over the same word, then readback
    @(negedge clk);
    drive_a1(1'b1, 4'b0100, 14'h0010, 32'h00AA0000);
    #1;
    check("bw_ready", {31'h0, a_m1_ready}, 32'h1);
    check("bw_wenb", {28'h0, a_wenb}, 32'hB);
    @(negedge clk);
    drive_a1(1'b1, 4'h0, 14'h0010, 32'h0);
    #1;
    check("bw_ack", {31'h0, a_m1_rvalid}, 32'h1);
    @(negedge clk);
    a_m1_valid = 1'b0;
    #1;
    check("bw_rvalid", {31'h0, a_m1_rvalid}, 32'h1);
    check("bw_rdata", a_m1_rdata, 32'hDEAABEEF);
    check("bw_m0_gated", a_m0_rdata, 32'h0);

    // Round-robin instance, both valid: m0,m1,m0,m1,m0,m1
    @(negedge clk);
    b_m0_valid = 1'b1; b_m0_addr = 14'h0100;
    b_m1_valid = 1'b1; b_m1_addr = 14'h0200;
    prev_m1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_m1 = (i % 2) == 1;
      check($sformatf("rr_m0_ready[%0d]", i), {31'h0, b_m0_ready}, {31'h0, !exp_m1});
      check($sformatf("rr_m1_ready[%0d]", i), {31'h0, b_m1_ready}, {31'h0, exp_m1});
      check($sformatf("rr_addr[%0d]", i), {18'h0, b_addr}, exp_m1 ? 32'h200 : 32'h100);
      if (i > 0) begin
        check($sformatf("rr_m0_rvalid[%0d]", i), {31'h0, b_m0_rvalid}, {31'h0, !prev_m1});
        check($sformatf("rr_m1_rvalid[%0d]", i), {31'h0, b_m1_rvalid}, {31'h0, prev_m1});
      end
      prev_m1 = exp_m1;
      @(negedge clk);
    end
    b_m1_valid = 1'b0;
    #1;
    check("rr_tail_m1_rvalid", {31'h0, b_m1_rvalid}, 32'h1);
    check("rr_tail_m0_ready", {31'h0, b_m0_ready}, 32'h1);
    check("rr_no_starve", {31'h0, b_starve}, 32'h0);
    @(negedge clk);
    b_m0_valid = 1'b0;
    #1;
    check("rr_tail_m0_rvalid", {31'h0, b_m0_rvalid}, 32'h1);

    // Reset pulse right after an m1 read grant drops its response
    @(negedge clk);
    drive_a1(1'b1, 4'h0, 14'h0010, 32'h0);
    #1;
    check("rp_m1_ready", {31'h0, a_m1_ready}, 32'h1);
    @(negedge clk);
    a_m1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rp_in_reset_rvalid", {31'h0, a_m1_rvalid}, 32'h0);
    check("rp_in_reset_wenb", {28'h0, a_wenb}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a0(1'b1, 4'h0, 14'h3FFF, 32'h0);
    #1;
    check("rp_m1_rvalid_after", {31'h0, a_m1_rvalid}, 32'h0);
    check("rp_m0_ready", {31'h0, a_m0_ready}, 32'h1);
    check("rp_addr_max", {18'h0, a_addr}, 32'h3FFF);
    @(negedge clk);
    a_m0_valid = 1'b0;
    #1;
    check("rp_m0_rvalid", {31'h0, a_m0_rvalid}, 32'h1);
    check("rp_m1_quiet", {31'h0, a_m1_rvalid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port on-chip SRAM (spram_model, 14-bit word address, 32-bit data, per-byte active-low write enables).
- Requester 0 is the CPU memory port. Requester 1 is a secondary master (DMA / housekeeping pass-through loader).
- Picks at most one access per cycle, drives the SRAM pins, and returns read data and write acks to the owner one cycle later.
- Sits between the retrosoc core and spram_model, clocked by the core clock.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- RR_MODE, 0, 0 = fixed priority to m0 with anti-starvation for m1; 1 = round-robin.
- MAX_WAIT, 4, consecutive lost cycles after which m1 is forced to win (RR_MODE=0 only); legal range 1..15.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; asynchronous assert, active-low
- m0_valid_i  in  1  m0 request valid
- m0_ready_o  out  1  m0 request accepted this cycle
- m0_wstrb_i  in  4  byte write strobes, active-high; 0 = read
- m0_addr_i  in  ADDR_WIDTH  word address
- m0_wdata_i  in  DATA_WIDTH  write data
- m0_rvalid_o  out  1  response for m0 (read data or write ack)
- m0_rdata_o  out  DATA_WIDTH  read data
- m1_* : same seven signals for requester 1
- ram_wenb_o  out  4  per-byte write enable to SRAM, active-low
- ram_addr_o  out  ADDR_WIDTH  SRAM address
- ram_wdata_o  out  DATA_WIDTH  SRAM write data
- ram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after the address
- starve_o  out  1  pulses 1 cycle whenever a forced m1 grant occurs

Behaviour:
- Reset values:
  - m*_ready_o=0, m*_rvalid_o=0, m*_rdata_o=0.
  - ram_wenb_o=4'hF, ram_addr_o=0, ram_wdata_o=0, starve_o=0.
  - Internal state: wait_cnt=0, last_gnt=1 (so m0 wins the first RR tie), rsp_owner=none.
- Handshake:
  - A request transfers on the rising edge where valid&ready=1.
  - A requester holds valid, wstrb, addr and wdata stable until ready.
  - ready is combinational from the valid inputs and registered arbiter state. It never depends on rvalid.
  - At most one ready is high per cycle.
- Arbitration, evaluated every cycle. Grant = winner selected by the rules below.
  - Only one valid: that requester wins.
  - RR_MODE=0, both valid:
    - m1 wins if wait_cnt==MAX_WAIT; starve_o=1 that cycle.
    - Otherwise m0 wins.
  - RR_MODE=1, both valid: the requester that is not last_gnt wins.
  - last_gnt updates on every grant.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) in each cycle where m1_valid=1 and m1 is not granted.
  - Clears on an m1 grant, or when m1_valid=0.
- SRAM drive (combinational from the grant):
  - ram_addr_o and ram_wdata_o = winner's addr/wdata.
  - ram_wenb_o = ~winner.wstrb.
  - No grant: ram_wenb_o=4'hF; addr/wdata hold their last registered value, kept in flops to avoid needless SRAM toggling.
  - During reset: ram_wenb_o=4'hF regardless of inputs.
- Response:
  - rsp_owner register captures the winner at the grant edge.
  - In the next cycle, the owner's rvalid_o=1 and its rdata_o=ram_rdata_i (passed through and gated to 0 for the non-owner).
  - Writes also produce rvalid; rdata is the SRAM output and is don't-care to the requester.
  - Latency: grant in cycle N -> rvalid in N+1. Back-to-back grants give one response per cycle, so throughput is 1 access/cycle.
- Boundaries:
  - Same-cycle grant and response for different requesters is legal.
  - Deasserting valid without ready is a protocol violation; covered by a sim assertion only.
  - Reset asserted mid-access: the pending response is dropped, no rvalid after reset release, and the first post-reset cycle is arbitrated fresh.
  - An address at ADDR_WIDTH max (14'h3FFF) passes unchanged; there is no wrap logic.

Decomposition:
- Shared package spram_arb_pkg holds:
  - Constants: OWNER_NONE=2'd0, OWNER_M0=2'd1, OWNER_M1=2'd2; BE_WIDTH=DATA_WIDTH/8.
  - Default MAX_WAIT.
- One sub-module, spram_arb_pick: pure-combinational winner selection taking valids, RR_MODE, last_gnt and wait_cnt; returns gnt[1:0] and force flag.
- Top keeps all flops: wait_cnt, last_gnt, rsp_owner, held addr/wdata.

Test Plan:
1. Reset: rst_n_i=0 with both valid=1 -> ram_wenb_o=4'hF, both ready=0, both rvalid=0. Release -> m0 granted first cycle.
2. m0 only: write addr 14'h0010 data 32'hDEADBEEF wstrb 4'hF, then read 14'h0010 -> ram_wenb_o=4'h0 during the write; m0_rvalid on N+1; read returns 32'hDEADBEEF on N+1.
3. Byte write: m1 writes wstrb 4'b0100 data 32'h00AA0000 over 32'hDEADBEEF -> ram_wenb_o=4'b1011; readback 32'hDEAABEEF.
4. RR_MODE=0, MAX_WAIT=4, both valid continuously -> grants m0,m0,m0,m0,m1 repeating; starve_o=1 on each 5th cycle; m1_rvalid one cycle after each m1 grant.
5. RR_MODE=1, both valid for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; responses arrive in the same order with 1-cycle latency.
6. Reset pulse on the cycle after an m1 read grant -> no m1_rvalid after release; the subsequent m0 read of 14'h3FFF completes with ram_addr_o=14'h3FFF.
